sdram_bist: RTL and testbench

Parametrised SDRAM built-in self-test sequencer that drives the user port of sdram_ctrl. It holds the controller in reset for a programmable interval, writes NUM_BURSTS bursts of a selectable data pattern, then reads every burst back and checks it against regenerated expected data. It reports error count, first-failure capture, timeout, pass/fail and iteration count, and can loop continuously for soak testing. It replaces hard-wired single-burst test sequencing in board top levels.

---
 rtl/sdram_bist.sv | 137 +++++++++++++
 tb/tb_sdram_bist.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist.sv
// sdram_bist: SDRAM self-test sequencer driving the sdram_ctrl user port.
// Writes NUM_BURSTS bursts of a pattern, reads them back and reports errors.
module sdram_bist #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16,
   parameter int BURST_LEN = 512,
   parameter int NUM_BURSTS = 4,
   parameter int START_ADDR = 0,
   parameter logic [15:0] SEED = 16'd777,
   parameter int RST_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_start,
   input  logic [1:0]          i_mode,
   input  logic                i_loop,
   output logic                o_ctrl_rstn,
   output logic [ADDR_W-1:0]   o_addr,
   output logic                o_sdram_en,
   output logic                o_rw,
   output logic [DATA_W-1:0]   o_datain,
   input  logic                i_ready,
   input  logic                i_writing,
   input  logic                i_dataval,
   input  logic [DATA_W-1:0]   i_dataout,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_pass,
   output logic                o_timeout,
   output logic [15:0]         o_err_count,
   output logic [ADDR_W+7:0]   o_first_err_addr,
   output logic [DATA_W-1:0]   o_first_err_data,
   output logic [7:0]          o_iter
);
   typedef enum logic [2:0] {CTRL_RST, IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST, NEXT, DONE} state_t;
   localparam logic [15:0] LSEED = (SEED == 16'd0) ? 16'd1 : SEED;
   localparam logic [DATA_W-1:0] AAAA = DATA_W'({DATA_W{2'b10}});
   state_t state, state_nxt;
   logic [31:0] rst_cnt, to_cnt, word_i, burst_b, w;
   logic [1:0] mode;
   logic [15:0] lfsr, lfsr_nxt;
   logic [DATA_W-1:0] pat, cmp_got, cmp_exp;
   logic [ADDR_W+7:0] cmp_w;
   logic cmp_v, err_seen, in_burst, acc, last, last_b, tmo, req_go;
   assign w = burst_b * BURST_LEN + word_i;
   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign pat = mode == 2'd0 ? DATA_W'(32'(SEED) + w) :
                mode == 2'd1 ? DATA_W'(lfsr) :
                mode == 2'd2 ? DATA_W'(1) << (w % DATA_W) :
                (word_i[0] ? AAAA : ~AAAA) ^ {DATA_W{burst_b[0]}};
   assign in_burst = state == WR_BURST || state == RD_BURST;
   assign acc = (state == WR_BURST && i_writing) || (state == RD_BURST && i_dataval);
   assign last = word_i == 32'(BURST_LEN - 1);
   assign last_b = burst_b == 32'(NUM_BURSTS - 1);
   assign tmo = in_burst && !acc && to_cnt == 32'(TIMEOUT_CYCLES - 1);
   assign req_go = (state == WR_REQ || state == RD_REQ) && i_ready;
   assign o_ctrl_rstn = state != CTRL_RST;
   assign o_busy = state inside {WR_REQ, WR_BURST, RD_REQ, RD_BURST, NEXT};
   assign o_pass = o_done && o_err_count == 16'd0 && !o_timeout;
   assign o_addr = ADDR_W'(START_ADDR + burst_b * BURST_LEN);
   assign o_datain = state == WR_BURST ? pat : '0;
   always_comb begin
      state_nxt = state;
      case (state)
         CTRL_RST: state_nxt = rst_cnt == 32'(RST_CYCLES - 1) ? IDLE : CTRL_RST;
         IDLE:     state_nxt = i_start && i_ready ? WR_REQ : IDLE;
         WR_REQ:   state_nxt = i_ready ? WR_BURST : WR_REQ;
         WR_BURST: state_nxt = tmo ? DONE : acc && last ? (last_b ? RD_REQ : WR_REQ) : WR_BURST;
         RD_REQ:   state_nxt = i_ready ? RD_BURST : RD_REQ;
         RD_BURST: state_nxt = tmo ? DONE : acc && last ? (last_b ? NEXT : RD_REQ) : RD_BURST;
         NEXT:     state_nxt = i_loop ? WR_REQ : DONE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= CTRL_RST;
         rst_cnt <= '0;
         to_cnt <= '0;
         word_i <= '0;
         burst_b <= '0;
         mode <= '0;
         lfsr <= LSEED;
         o_sdram_en <= 1'b0;
         o_rw <= 1'b0;
         cmp_v <= 1'b0;
         cmp_got <= '0;
         cmp_exp <= '0;
         cmp_w <= '0;
         err_seen <= 1'b0;
         o_done <= 1'b0;
         o_timeout <= 1'b0;
         o_err_count <= '0;
         o_first_err_addr <= '0;
         o_first_err_data <= '0;
         o_iter <= '0;
      end else begin
         state <= state_nxt;
         if (state == CTRL_RST) rst_cnt <= rst_cnt + 1;
         to_cnt <= in_burst && !acc ? to_cnt + 1 : '0;
         o_sdram_en <= req_go;
         if (req_go) o_rw <= state == RD_REQ;
         if (acc) begin
            word_i <= last ? '0 : word_i + 1;
            lfsr <= lfsr_nxt;
         end
         if (acc && last) burst_b <= last_b ? '0 : burst_b + 1;
         // LFSR restarts from the seed at the start of every write and read phase
         if (state == IDLE || state == NEXT || (state == WR_BURST && acc && last && last_b)) lfsr <= LSEED;
         cmp_v <= state == RD_BURST && i_dataval;
         cmp_got <= i_dataout;
         cmp_exp <= pat;
         cmp_w <= (ADDR_W+8)'(w);
         if (state == IDLE && i_start && i_ready) begin
            mode <= i_mode;
            err_seen <= 1'b0;
            o_done <= 1'b0;
            o_timeout <= 1'b0;
            o_err_count <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
            o_iter <= '0;
         end else if (cmp_v && cmp_got != cmp_exp) begin
            if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
            if (!err_seen) begin
               err_seen <= 1'b1;
               o_first_err_addr <= cmp_w;
               o_first_err_data <= cmp_got;
            end
         end
         if (state == NEXT) o_iter <= o_iter + 8'd1;
         if (tmo) o_timeout <= 1'b1;
         if (state != DONE && state_nxt == DONE) o_done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: directed + randomized checks of sdram_bist against a loopback
// controller model and a pattern reference computed from word indices.
module tb_sdram_bist;
   localparam int BL = 8;
   localparam int NB = 2;
   logic i_clk = 1'b0, i_rstn = 1'b0, i_start = 1'b0, i_loop = 1'b0;
   logic [1:0] i_mode = 2'd0;
   logic i_ready, i_writing, i_dataval;
   logic [15:0] i_dataout;
   logic o_ctrl_rstn, o_sdram_en, o_rw, o_busy, o_done, o_pass, o_timeout;
   logic [14:0] o_addr;
   logic [15:0] o_datain, o_err_count, o_first_err_data;
   logic [22:0] o_first_err_addr;
   logic [7:0] o_iter;
   int n_cmp = 0, n_bad = 0;
   logic ready_low = 1'b0, stall_rd = 1'b0;
   int inj_w = -1;
   logic [15:0] inj_mask = 16'd0;
   logic [15:0] mem [0:15];
   logic [15:0] lf [0:15];
   int addr_q[$];

   always #5 i_clk = ~i_clk;

   sdram_bist #(.ADDR_W(15), .DATA_W(16), .BURST_LEN(BL), .NUM_BURSTS(NB), .START_ADDR(0),
      .SEED(16'd777), .RST_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_mode(i_mode), .i_loop(i_loop),
      .o_ctrl_rstn(o_ctrl_rstn), .o_addr(o_addr), .o_sdram_en(o_sdram_en), .o_rw(o_rw),
      .o_datain(o_datain), .i_ready(i_ready), .i_writing(i_writing), .i_dataval(i_dataval),
      .i_dataout(i_dataout), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_timeout(o_timeout), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr),
      .o_first_err_data(o_first_err_data), .o_iter(o_iter));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 counted from 1
   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   function automatic logic [15:0] pat(input logic [1:0] m, input int w);
      case (m)
         2'd0: return 16'(777 + w);
         2'd1: return lf[w];
         2'd2: return 16'(1 << (w % 16));
         default: return (((w % BL) % 2) != 0 ? 16'hAAAA : 16'h5555) ^ (((w / BL) % 2) != 0 ? 16'hFFFF : 16'h0000);
      endcase
   endfunction

   // Loopback controller: accepts a burst per o_sdram_en, strobes with random gaps
   initial begin
      logic [14:0] a;
      logic rw;
      i_ready = 1'b0; i_writing = 1'b0; i_dataval = 1'b0; i_dataout = 16'd0;
      forever begin
         @(negedge i_clk);
         i_writing = 1'b0; i_dataval = 1'b0;
         i_ready = !ready_low;
         if (o_sdram_en) begin
            a = o_addr; rw = o_rw;
            addr_q.push_back(int'(a));
            i_ready = 1'b0;
            if (rw && stall_rd) begin
               for (int t = 0; t < 300 && o_busy; t++) @(negedge i_clk);
            end else begin
               for (int k = 0; k < BL; k++) begin
                  repeat ($urandom_range(0, 2)) @(negedge i_clk);
                  if (!rw) begin
                     i_writing = 1'b1;
                     mem[(int'(a) + k) % 16] = o_datain;
                  end else begin
                     i_dataval = 1'b1;
                     i_dataout = mem[(int'(a) + k) % 16] ^ ((int'(a) + k == inj_w) ? inj_mask : 16'd0);
                  end
                  @(negedge i_clk);
                  i_writing = 1'b0; i_dataval = 1'b0;
               end
            end
            i_ready = !ready_low;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_ctrl_rstn"}, 32'(o_ctrl_rstn), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_pass"}, 32'(o_pass), 0);
      chk({tag, "_timeout"}, 32'(o_timeout), 0);
      chk({tag, "_err"}, 32'(o_err_count), 0);
      chk({tag, "_iter"}, 32'(o_iter), 0);
      chk({tag, "_en"}, 32'(o_sdram_en), 0);
      chk({tag, "_rw"}, 32'(o_rw), 0);
      chk({tag, "_addr"}, 32'(o_addr), 0);
      chk({tag, "_datain"}, 32'(o_datain), 0);
      chk({tag, "_ferr_addr"}, 32'(o_first_err_addr), 0);
      chk({tag, "_ferr_data"}, 32'(o_first_err_data), 0);
   endtask

   task automatic release_and_count(input string tag);
      int n;
      @(negedge i_clk); i_rstn = 1'b1;
      n = 0;
      while (!o_ctrl_rstn && n < 100) begin
         @(posedge i_clk); #1;
         n++;
      end
      chk(tag, n, 16);
   endtask

   task automatic start_run(input logic [1:0] m, input int iw, input logic [15:0] im, input logic lp);
      for (int k = 0; k < 16; k++) mem[k] = 16'd0;
      addr_q.delete();
      i_mode = m; inj_w = iw; inj_mask = im; i_loop = lp;
      @(negedge i_clk); i_start = 1'b1;
      @(negedge i_clk); i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int t = 0; t < 3000 && !o_done; t++) @(negedge i_clk);
      chk({tag, "_done"}, 32'(o_done), 1);
      chk({tag, "_busy"}, 32'(o_busy), 0);
   endtask

   task automatic check_mem_addr(input string tag, input logic [1:0] m, input int passes);
      for (int k = 0; k < BL * NB; k++) chk($sformatf("%s_word%0d", tag, k), 32'(mem[k]), 32'(pat(m, k)));
      chk({tag, "_nreq"}, addr_q.size(), 2 * NB * passes);
      foreach (addr_q[j]) chk($sformatf("%s_addr%0d", tag, j), addr_q[j], (j % NB) * BL);
   endtask

   task automatic run_err(input string tag, input logic [1:0] m, input int iw, input int bitn);
      logic [15:0] mask;
      mask = 16'(1 << bitn);
      start_run(m, iw, mask, 1'b0);
      wait_done(tag);
      chk({tag, "_err"}, 32'(o_err_count), 1);
      chk({tag, "_ferr_addr"}, 32'(o_first_err_addr), iw);
      chk({tag, "_ferr_data"}, 32'(o_first_err_data), 32'(pat(m, iw) ^ mask));
      chk({tag, "_pass"}, 32'(o_pass), 0);
      check_mem_addr(tag, m, 1);
   endtask

   initial begin
      int n;
      lf[0] = 16'd777;
      for (int k = 1; k < 16; k++) lf[k] = lfsr_step(lf[k-1]);
      // reset and controller-reset interval
      repeat (5) @(posedge i_clk);
      #1 check_reset_state("rst");
      release_and_count("ctrl_rst_len");
      chk("idle_busy", 32'(o_busy), 0);
      // start is not accepted while the controller is not ready
      ready_low = 1'b1;
      repeat (2) @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk); i_start = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("blocked_busy", 32'(o_busy), 0);
      chk("blocked_done", 32'(o_done), 0);
      ready_low = 1'b0;
      repeat (2) @(negedge i_clk);
      // clean passes in every mode
      for (int m = 0; m < 4; m++) begin
         start_run(2'(m), -1, 16'd0, 1'b0);
         wait_done($sformatf("m%0d", m));
         chk($sformatf("m%0d_pass", m), 32'(o_pass), 1);
         chk($sformatf("m%0d_err", m), 32'(o_err_count), 0);
         chk($sformatf("m%0d_iter", m), 32'(o_iter), 1);
         chk($sformatf("m%0d_timeout", m), 32'(o_timeout), 0);
         check_mem_addr($sformatf("m%0d", m), 2'(m), 1);
      end
      // single injected error: bit 0 of word 5
      run_err("inj5", 2'd0, 5, 0);
      // randomized mode / word / bit
      for (int r = 0; r < 3; r++)
         run_err($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      // timeout when reads never return
      stall_rd = 1'b1;
      start_run(2'd0, -1, 16'd0, 1'b0);
      for (int t = 0; t < 500 && !(o_sdram_en && o_rw); t++) @(negedge i_clk);
      n = 0;
      while (!o_timeout && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
      chk("tmo_cycles", n, 64);
      chk("tmo_done", 32'(o_done), 1);
      chk("tmo_pass", 32'(o_pass), 0);
      repeat (3) @(negedge i_clk);
      stall_rd = 1'b0;
      repeat (3) @(negedge i_clk);
      // three looped passes with an error each pass
      start_run(2'd0, 3, 16'h0100, 1'b1);
      for (int t = 0; t < 3000 && o_iter != 8'd2; t++) @(negedge i_clk);
      i_loop = 1'b0;
      wait_done("loop");
      chk("loop_iter", 32'(o_iter), 3);
      chk("loop_err", 32'(o_err_count), 3);
      chk("loop_ferr_addr", 32'(o_first_err_addr), 3);
      chk("loop_ferr_data", 32'(o_first_err_data), 32'(pat(2'd0, 3) ^ 16'h0100));
      chk("loop_pass", 32'(o_pass), 0);
      chk("loop_nreq", addr_q.size(), 2 * NB * 3);
      // reset in the middle of a write burst
      start_run(2'd0, -1, 16'd0, 1'b0);
      for (int t = 0; t < 500 && !(o_sdram_en && !o_rw); t++) @(negedge i_clk);
      repeat (3) @(negedge i_clk);
      i_rstn = 1'b0;
      @(posedge i_clk); #1 check_reset_state("midrst");
      repeat (2) @(posedge i_clk);
      release_and_count("ctrl_rst_len2");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
